mc_req_dispatch: RTL and testbench



---
 rtl/mc_dispatch_pkg.sv | 37 +++
 rtl/mc_dispatch_fifo.sv | 47 ++++
 rtl/mc_req_dispatch.sv | 133 +++++++++++++
 tb/tb_mc_req_dispatch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_dispatch_pkg.sv
// Shared types and default configuration for the request dispatcher.
// split_addr and req_entry_t describe the default geometry; the parametrised top slices generically.
package mc_dispatch_pkg;

    localparam int unsigned DEF_NUM_BANKS   = 4;
    localparam int unsigned DEF_ROW_W       = 14;
    localparam int unsigned DEF_COL_W       = 7;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_TAG_W       = 4;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;
    localparam int unsigned DEF_BUSY_MARGIN = 2;
    localparam int unsigned DEF_BANK_W      = $clog2(DEF_NUM_BANKS);
    localparam int unsigned DEF_ADDR_W      = DEF_ROW_W + DEF_BANK_W + DEF_COL_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic                  rdwr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wr_data;
    } req_entry_t;

    typedef struct packed {
        logic [DEF_ROW_W-1:0]  row;
        logic [DEF_BANK_W-1:0] bank;
        logic [DEF_COL_W-1:0]  col;
    } addr_fields_t;

    // Address layout is {row, bank, col}, so the split is a reinterpretation.
    function automatic addr_fields_t split_addr(input logic [DEF_ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/mc_dispatch_fifo.sv
// Synchronous FIFO with occupancy count; push while full and pop while empty are ignored.
module mc_dispatch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mc_req_dispatch.sv
// System request FIFO plus in-order dispatcher to per-bank controllers with rolling tags.
// Optional MC_DEC_STALL_CNT_EN adds a saturating count of cycles the selected bank held off.
module mc_req_dispatch
    import mc_dispatch_pkg::*;
#(
    parameter int unsigned NUM_BANKS   = DEF_NUM_BANKS,
    parameter int unsigned ROW_W       = DEF_ROW_W,
    parameter int unsigned COL_W       = DEF_COL_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TAG_W       = DEF_TAG_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned BUSY_MARGIN = DEF_BUSY_MARGIN
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        sys__mc__dram_req,
    input  logic                                        sys__mc__dram_rdwr,
    input  logic [ROW_W+$clog2(NUM_BANKS)+COL_W-1:0]    sys__mc__dram_addr,
    input  logic [DATA_W-1:0]                           sys__mc__dram_wr_data,
    output logic                                        mc__sys__dram_busy,
    output logic                                        mc__sys__dram_ovfl,
    output logic [NUM_BANKS-1:0]                        dec__bnc__valid,
    output logic [ROW_W-1:0]                            dec__bnc__page_addr,
    output logic [COL_W-1:0]                            dec__bnc__col_addr,
    output logic                                        dec__bnc__rdwr,
    output logic [DATA_W-1:0]                           dec__bnc__wr_data,
    output logic [TAG_W-1:0]                            dec__bnc__tag,
`ifdef MC_DEC_STALL_CNT_EN
    output logic [15:0]                                 dec__stat__stall_cnt,
`endif
    input  logic [NUM_BANKS-1:0]                        bnc__dec__ready
);

    localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
    localparam int unsigned ADDR_W  = ROW_W + BANK_W + COL_W;
    localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic               push, pop, full, empty, hs;
    logic [CNT_W-1:0]   count, count_d;
    logic [ENTRY_W-1:0] head;
    logic               head_rdwr;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;

    state_e             state_q;
    logic [NUM_BANKS-1:0] valid_q;
    logic [ROW_W-1:0]   page_q;
    logic [COL_W-1:0]   col_q;
    logic               rdwr_q;
    logic [DATA_W-1:0]  data_q;
    logic [TAG_W-1:0]   tag_q, tag_cnt_q, tag_cnt_d;
    logic               busy_q, ovfl_q;

    mc_dispatch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({sys__mc__dram_rdwr, sys__mc__dram_addr, sys__mc__dram_wr_data}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign {head_rdwr, head_addr, head_data} = head;

    // valid_q only ever has the selected bank's bit set, so the masked OR is the handshake.
    assign hs        = |(valid_q & bnc__dec__ready);
    assign push      = sys__mc__dram_req && !full;
    assign pop       = !empty && ((state_q == IDLE) || hs);
    assign tag_cnt_d = tag_cnt_q + TAG_W'(hs);
    assign count_d   = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            page_q    <= '0;
            col_q     <= '0;
            rdwr_q    <= 1'b0;
            data_q    <= '0;
            tag_q     <= '0;
            tag_cnt_q <= '0;
            busy_q    <= 1'b0;
            ovfl_q    <= 1'b0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
            busy_q    <= (count_d >= CNT_W'(FIFO_DEPTH - BUSY_MARGIN));
            if (sys__mc__dram_req && full) ovfl_q <= 1'b1;
            if (pop) begin
                state_q <= ISSUE;
                valid_q <= NUM_BANKS'(1) << head_addr[BANK_W+COL_W-1:COL_W];
                page_q  <= head_addr[ADDR_W-1:BANK_W+COL_W];
                col_q   <= head_addr[COL_W-1:0];
                rdwr_q  <= head_rdwr;
                data_q  <= head_data;
                tag_q   <= tag_cnt_d;
            end else if (hs) begin
                state_q <= IDLE;
                valid_q <= '0;
            end
        end
    end

`ifdef MC_DEC_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ISSUE) && !hs && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign dec__stat__stall_cnt = stall_cnt_q;
`endif

    assign mc__sys__dram_busy  = busy_q;
    assign mc__sys__dram_ovfl  = ovfl_q;
    assign dec__bnc__valid     = valid_q;
    assign dec__bnc__page_addr = page_q;
    assign dec__bnc__col_addr  = col_q;
    assign dec__bnc__rdwr      = rdwr_q;
    assign dec__bnc__wr_data   = data_q;
    assign dec__bnc__tag       = tag_q;

endmodule

// File: tb/tb_mc_req_dispatch.sv
// Scoreboard bench for mc_req_dispatch: queue-based reference model, negedge monitor.
module tb_mc_req_dispatch;

    localparam int NB     = 4;
    localparam int ROW_W  = 14;
    localparam int COL_W  = 7;
    localparam int BANK_W = 2;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int ADDR_W = ROW_W + BANK_W + COL_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req = 1'b0;
    logic              rdwr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [NB-1:0]     ready = '0;
    logic              busy, ovfl, b_rdwr;
    logic [NB-1:0]     valid;
    logic [ROW_W-1:0]  page;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] b_data;
    logic [TAG_W-1:0]  tag;
`ifdef MC_DEC_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    mc_req_dispatch #(
        .NUM_BANKS   (NB),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W),
        .DATA_W      (DATA_W),
        .TAG_W       (TAG_W),
        .FIFO_DEPTH  (DEPTH),
        .BUSY_MARGIN (MARGIN)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .sys__mc__dram_req     (req),
        .sys__mc__dram_rdwr    (rdwr),
        .sys__mc__dram_addr    (addr),
        .sys__mc__dram_wr_data (wr_data),
        .mc__sys__dram_busy    (busy),
        .mc__sys__dram_ovfl    (ovfl),
        .dec__bnc__valid       (valid),
        .dec__bnc__page_addr   (page),
        .dec__bnc__col_addr    (col),
        .dec__bnc__rdwr        (b_rdwr),
        .dec__bnc__wr_data     (b_data),
        .dec__bnc__tag         (tag),
`ifdef MC_DEC_STALL_CNT_EN
        .dec__stat__stall_cnt  (stall_cnt),
`endif
        .bnc__dec__ready       (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdwr;
        int unsigned addr;
        logic [31:0] data;
        int unsigned tag;
    } txn_t;

    txn_t        pend[$];
    txn_t        exp_q[$];
    bit          loaded, ovfl_exp, busy_exp;
    int unsigned acc_cnt, stall_exp;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int unsigned bank_of(int unsigned a);
        return (a >> COL_W) % NB;
    endfunction

    function automatic int unsigned mk_addr(int unsigned r, int unsigned b, int unsigned c);
        return r * (1 << (COL_W + BANK_W)) + b * (1 << COL_W) + c;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        exp_q.delete();
        loaded    = 0;
        ovfl_exp  = 0;
        busy_exp  = 0;
        acc_cnt   = 0;
        stall_exp = 0;
    endtask

    // One clock edge of the reference: queue of accepted-but-unhandshaken requests,
    // the front one sitting in the issue slot when 'loaded'.
    task automatic model_step();
        int unsigned occ;
        bit hs, full, acc, popped;
        txn_t t;
        occ  = pend.size() - (loaded ? 1 : 0);
        hs   = loaded && ready[bank_of(pend[0].addr)];
        full = (occ == DEPTH);
        acc  = req && !full;
        if (req && full) ovfl_exp = 1;
        if (loaded && !hs && stall_exp < 16'hFFFF) stall_exp++;
        if (hs) void'(pend.pop_front());
        popped = (!loaded || hs) && (occ > 0);
        loaded = popped || (loaded && !hs);
        if (acc) begin
            t.rdwr = rdwr;
            t.addr = addr;
            t.data = wr_data;
            t.tag  = acc_cnt % (1 << TAG_W);
            acc_cnt++;
            pend.push_back(t);
            exp_q.push_back(t);
        end
        busy_exp = (occ + (acc ? 1 : 0) - (popped ? 1 : 0)) >= (DEPTH - MARGIN);
    endtask

    task automatic cyc(bit r, bit rw, int unsigned a, logic [31:0] d, logic [NB-1:0] rdy);
        req     = r;
        rdwr    = rw;
        addr    = ADDR_W'(a);
        wr_data = d;
        ready   = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((pend.size() != 0) && (n < 100)) begin
            cyc(0, 0, 0, 0, '1);
            n++;
        end
        chk("drain_done", 64'(pend.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a handshake.
    always @(negedge clk) begin
        logic [NB-1:0] ev;
        txn_t t;
        ev = loaded ? (NB'(1) << bank_of(pend[0].addr)) : '0;
        chk("valid", 64'(valid), 64'(ev));
        chk("busy", 64'(busy), 64'(busy_exp));
        chk("ovfl", 64'(ovfl), 64'(ovfl_exp));
`ifdef MC_DEC_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
`endif
        if (valid != '0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: got %0h expected no transaction at %0t", valid, $time);
            end else begin
                t = exp_q[0];
                chk("valid_bank", 64'(valid), 64'(NB'(1) << bank_of(t.addr)));
                chk("page", 64'(page), 64'(t.addr >> (COL_W + BANK_W)));
                chk("col", 64'(col), 64'(t.addr % (1 << COL_W)));
                chk("rdwr", 64'(b_rdwr), 64'(t.rdwr));
                chk("wr_data", 64'(b_data), 64'(t.data));
                chk("tag", 64'(tag), 64'(t.tag));
                if ((valid & ready) != '0) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single read: row 5, bank 2, col 0x11.
        cyc(1, 1, 'hB11, 32'h0, '1);
        repeat (4) cyc(0, 0, 0, 0, '1);

        // Back-to-back writes rotating through the banks.
        for (int unsigned i = 0; i < 8; i++)
            cyc(1, 0, mk_addr(i + 1, i % NB, i), $urandom, '1);
        drain();

        // Head to bank 1 held off while other banks are ready.
        cyc(1, 1, mk_addr(3, 1, 7), $urandom, 4'b1101);
        for (int unsigned i = 0; i < 11; i++)
            cyc(i < 3, 0, mk_addr(i, (i + 2) % NB, i), $urandom, 4'b1101);
        drain();

        // Fill with every bank stalled, then drain in order.
        for (int unsigned i = 0; i < 10; i++)
            cyc(1, i[0], $urandom, $urandom, '0);
        repeat (2) cyc(0, 0, 0, 0, '0);
        drain();

        // Random traffic: exercises tag wrap and ready back-pressure.
        for (int unsigned i = 0; i < 500; i++)
            cyc(($urandom % 3) != 0, 1'($urandom), $urandom, $urandom,
                NB'($urandom | $urandom));
        drain();

        // Reset while issuing with requests queued.
        for (int unsigned i = 0; i < 4; i++)
            cyc(1, 0, $urandom, $urandom, '0);
        reset = 1'b1;
        model_clear();
        #2;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovfl", 64'(ovfl), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) cyc(0, 0, 0, 0, '1);

        for (int unsigned i = 0; i < 200; i++)
            cyc(1'($urandom), 1'($urandom), $urandom, $urandom, NB'($urandom));
        drain();
        @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
